// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and its helpers:
// memory geometry, sequencer state encoding and requester port indices.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way winner select. A lone requester always
// wins; on a tie either port 0 wins (FIXED_PRIO != 0) or the port that was
// not granted last time wins (round-robin).
module rr_pick2
  import dmem_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic valid,
  output logic winner
);

  // Resolve the winner from the request pair and grant history
  always_comb begin
    valid  = req0 | req1;
    winner = PORT_CPU;
    if (req0 && req1)
      winner = (FIXED_PRIO != 0) ? PORT_CPU : ~last_gnt;
    else if (req1)
      winner = PORT_DMA;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single 256x8 data-memory port between the CPU
// (port 0) and the DMA/debug loader (port 1). Each accepted command gets a
// one-cycle gnt and a one-cycle mem_read/mem_write strobe; reads return
// through rdata with an rvalid pulse two cycles after the grant, covering
// the memory's registered read.
// Optional feature: define DMEM_ARB_STATS_EN to add saturating grant and
// conflict counters (gnt_cnt0, gnt_cnt1, conflict_cnt) with stats_clr.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1,
  output logic [15:0]       conflict_cnt
`endif
);

  state_t              state;
  logic                owner;
  logic                cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic                last_gnt;

  logic                pick_valid;
  logic                pick_win;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  rr_pick2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .valid    (pick_valid),
    .winner   (pick_win)
  );

  assign sel_we    = (pick_win == PORT_DMA) ? we1    : we0;
  assign sel_addr  = (pick_win == PORT_DMA) ? addr1  : addr0;
  assign sel_wdata = (pick_win == PORT_DMA) ? wdata1 : wdata0;

  // The captured command is held between transactions, so the memory
  // address/data buses keep their last values outside the issue cycle.
  assign mem_address    = cmd_addr;
  assign mem_write_data = cmd_wdata;

  // Sequencer: capture in IDLE, strobe in ISSUE, collect read data in RESP.
  // Strobes and handshakes are registered so they are glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      owner     <= PORT_CPU;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      last_gnt  <= PORT_DMA;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner     <= pick_win;
            cmd_we    <= sel_we;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
            // Raised here so they are high exactly during ISSUE
            mem_write <= sel_we;
            mem_read  <= ~sel_we;
            gnt0      <= (pick_win == PORT_CPU);
            gnt1      <= (pick_win == PORT_DMA);
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          last_gnt <= owner;
          state    <= cmd_we ? ST_IDLE : ST_RESP;
        end
        ST_RESP: begin
          // Memory output is valid this cycle; rvalid lands in the next IDLE
          rdata   <= mem_read_data;
          rvalid0 <= (owner == PORT_CPU);
          rvalid1 <= (owner == PORT_DMA);
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating grant/conflict counters; stats_clr wins over increments
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_cnt0     <= '0;
      gnt_cnt1     <= '0;
      conflict_cnt <= '0;
    end else if (stats_clr) begin
      gnt_cnt0     <= '0;
      gnt_cnt1     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt0 && (gnt_cnt0 != 16'hFFFF)) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (gnt1 && (gnt_cnt1 != 16'hFFFF)) gnt_cnt1 <= gnt_cnt1 + 16'd1;
      if ((state == ST_IDLE) && req0 && req1 && (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule
